// File: rtl/mux_scan_sampler.sv
// rtl/mux_scan_sampler.sv - scans a 4:1 mux through its select lines and packs the samples into a word
// One-entry output buffer; a completed word that finds the buffer occupied is dropped and flagged.
module mux_scan_sampler #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic [1:0]         sel,
  output logic [3:0]         word,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               overrun,
  input  logic               clear
);

  typedef enum logic [0:0] {
    IDLE,
    SETTLE
  } state_t;

  state_t             state_q;
  logic [1:0]         sel_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [3:0]         shadow_q;
  logic [3:0]         word_q;
  logic               word_valid_q;
  logic               overrun_q;

  logic [3:0]         word_d;
  logic               buf_free_d;

  // The final channel goes straight into the word; shadow[3] is not yet visible.
  assign word_d     = {mux_out, shadow_q[2:0]};
  assign buf_free_d = !word_valid_q || word_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      cnt_q        <= '0;
      dwell_q      <= '0;
      shadow_q     <= 4'd0;
      word_q       <= 4'd0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (word_valid_q && word_ready) begin
        word_valid_q <= 1'b0;
      end
      if (clear) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          sel_q <= 2'd0;
          cnt_q <= '0;
          if (en) begin
            state_q <= SETTLE;
            dwell_q <= dwell;
          end
        end
        SETTLE: begin
          if (!en) begin
            state_q  <= IDLE;
            sel_q    <= 2'd0;
            cnt_q    <= '0;
            shadow_q <= 4'd0;
          end else if (cnt_q != dwell_q) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            shadow_q[sel_q] <= mux_out;
            sel_q           <= sel_q + 2'd1;
            cnt_q           <= '0;
            dwell_q         <= dwell;
            if (sel_q == 2'd3) begin
              // A drain in the same cycle frees the slot, so the new word wins.
              if (buf_free_d) begin
                word_q       <= word_d;
                word_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= 2'd0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb/tb_mux_scan_sampler.sv - self-checking bench for mux_scan_sampler
// Directed scenarios against constants, then random traffic against a timestamp-based reference model.
module tb_mux_scan_sampler;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic          mux_out;
  logic [1:0]    sel;
  logic [3:0]    word;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic          overrun;
  logic          clear = 1'b0;
  logic [3:0]    d = 4'd0;

  int total = 0;
  int bad = 0;

  // Reference model: scan position plus the absolute edge number of the next sample.
  bit       m_active = 0;
  int       m_ch = 0;
  longint   m_now = 0;
  longint   m_due = 0;
  bit [3:0] m_shadow = 0;
  bit [3:0] m_word = 0;
  bit       m_valid = 0;
  bit       m_ovr = 0;

  always #5 clk = ~clk;

  // Downstream 4:1 mux
  assign mux_out = d[sel];

  mux_scan_sampler #(.DWELL_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .dwell      (dwell),
    .mux_out    (mux_out),
    .sel        (sel),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun),
    .clear      (clear)
  );

  task automatic cycle();
    bit old_valid;
    m_now++;
    if (!rst_n) begin
      m_active = 0; m_ch = 0; m_shadow = 0;
      m_word = 0; m_valid = 0; m_ovr = 0;
    end else begin
      old_valid = m_valid;
      if (m_valid && word_ready) m_valid = 0;
      if (clear) m_ovr = 0;
      if (!m_active) begin
        if (en) begin
          m_active = 1;
          m_ch = 0;
          m_due = m_now + longint'(dwell) + 1;
        end
      end else if (!en) begin
        m_active = 0;
      end else if (m_now == m_due) begin
        m_shadow[m_ch] = d[m_ch];
        if (m_ch == 3) begin
          if (!old_valid || word_ready) begin
            m_word = m_shadow;
            m_valid = 1;
          end else begin
            m_ovr = 1;
          end
        end
        m_ch = (m_ch + 1) % 4;
        m_due = m_now + longint'(dwell) + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; word_ready = 1'b0; clear = 1'b0; dwell = '0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; word_ready = 1'b1; d = 4'b1111;
    cycle();
    cycle();
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    total++; if (word !== 4'd0) begin bad++; $display("FAIL reset_word got=%b exp=0000", word); end
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_basic();
    logic exp_v;
    rst_n = 1'b1; d = 4'b1010; dwell = '0; en = 1'b1; word_ready = 1'b1;
    cycle();
    total++; if (sel !== 2'd0 || word_valid !== 1'b0) begin
      bad++; $display("FAIL basic_start sel=%0d valid=%b exp sel=0 valid=0", sel, word_valid);
    end
    for (int k = 1; k <= 8; k++) begin
      cycle();
      exp_v = (k == 4) || (k == 8);
      total++; if (sel !== 2'(k % 4)) begin bad++; $display("FAIL basic_sel k=%0d got=%0d exp=%0d", k, sel, k % 4); end
      total++; if (word_valid !== exp_v) begin bad++; $display("FAIL basic_valid k=%0d got=%b exp=%b", k, word_valid, exp_v); end
      if (exp_v) begin
        total++; if (word !== 4'b1010) begin bad++; $display("FAIL basic_word k=%0d got=%b exp=1010", k, word); end
      end
    end
  endtask

  task automatic test_dwell();
    do_reset();
    dwell = 4'd3; d = 4'b0110; en = 1'b1; word_ready = 1'b1;
    cycle();
    for (int k = 1; k <= 16; k++) begin
      cycle();
      if (k == 2) d = 4'b1001;
      total++; if (sel !== 2'((k / 4) % 4)) begin bad++; $display("FAIL dwell_sel k=%0d got=%0d exp=%0d", k, sel, (k / 4) % 4); end
    end
    total++; if (word_valid !== 1'b1 || word !== 4'b1001) begin
      bad++; $display("FAIL dwell_word got=%b valid=%b exp=1001 valid=1", word, word_valid);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    dwell = '0; d = 4'b0011; en = 1'b1; word_ready = 1'b0;
    cycle();
    repeat (4) cycle();
    total++; if (word_valid !== 1'b1 || word !== 4'b0011) begin
      bad++; $display("FAIL ovr_first got=%b valid=%b exp=0011 valid=1", word, word_valid);
    end
    d = 4'b1100;
    repeat (4) cycle();
    total++; if (word !== 4'b0011 || overrun !== 1'b1 || word_valid !== 1'b1) begin
      bad++; $display("FAIL ovr_drop word=%b ovr=%b valid=%b exp word=0011 ovr=1 valid=1", word, overrun, word_valid);
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    repeat (2) cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    total++; if (overrun !== 1'b1 || word !== 4'b0011) begin
      bad++; $display("FAIL ovr_set_wins ovr=%b word=%b exp ovr=1 word=0011", overrun, word);
    end
  endtask

  task automatic test_drain_coincident();
    do_reset();
    dwell = '0; d = 4'b0011; en = 1'b1; word_ready = 1'b0;
    cycle();
    repeat (4) cycle();
    d = 4'b0101;
    repeat (3) cycle();
    word_ready = 1'b1;
    cycle();
    word_ready = 1'b0;
    total++; if (word !== 4'b0101 || word_valid !== 1'b1 || overrun !== 1'b0) begin
      bad++; $display("FAIL drain_coinc word=%b valid=%b ovr=%b exp word=0101 valid=1 ovr=0", word, word_valid, overrun);
    end
    cycle();
    total++; if (word_valid !== 1'b1 || word !== 4'b0101) begin
      bad++; $display("FAIL drain_hold word=%b valid=%b exp word=0101 valid=1", word, word_valid);
    end
  endtask

  task automatic test_abort();
    do_reset();
    dwell = '0; d = 4'b0011; en = 1'b1; word_ready = 1'b0;
    cycle();
    repeat (6) cycle();
    total++; if (sel !== 2'd2) begin bad++; $display("FAIL abort_pre_sel got=%0d exp=2", sel); end
    en = 1'b0;
    cycle();
    total++; if (sel !== 2'd0 || word !== 4'b0011 || word_valid !== 1'b1) begin
      bad++; $display("FAIL abort_idle sel=%0d word=%b valid=%b exp sel=0 word=0011 valid=1", sel, word, word_valid);
    end
    d = 4'b0101;
    repeat (3) cycle();
    total++; if (sel !== 2'd0 || word !== 4'b0011 || word_valid !== 1'b1 || overrun !== 1'b0) begin
      bad++; $display("FAIL abort_hold sel=%0d word=%b valid=%b ovr=%b", sel, word, word_valid, overrun);
    end
    word_ready = 1'b1;
    cycle();
    word_ready = 1'b0;
    total++; if (word_valid !== 1'b0 || word !== 4'b0011) begin
      bad++; $display("FAIL abort_consume valid=%b word=%b exp valid=0 word=0011", word_valid, word);
    end
    en = 1'b1;
    cycle();
    repeat (4) cycle();
    total++; if (word_valid !== 1'b1 || word !== 4'b0101 || overrun !== 1'b0) begin
      bad++; $display("FAIL abort_restart word=%b valid=%b ovr=%b exp word=0101 valid=1 ovr=0", word, word_valid, overrun);
    end
  endtask

  task automatic test_random();
    logic [1:0] exp_sel;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      en         = ($urandom_range(0, 24) != 0);
      dwell      = DW'($urandom_range(0, 3));
      d          = 4'($urandom);
      word_ready = ($urandom_range(0, 2) == 0);
      clear      = ($urandom_range(0, 7) == 0);
      cycle();
      exp_sel = m_active ? 2'(m_ch) : 2'd0;
      total++; if (sel !== exp_sel) begin bad++; $display("FAIL rand_sel c=%0d got=%0d exp=%0d", c, sel, exp_sel); end
      total++; if (word_valid !== m_valid) begin bad++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, word_valid, m_valid); end
      total++; if (word !== m_word) begin bad++; $display("FAIL rand_word c=%0d got=%b exp=%b", c, word, m_word); end
      total++; if (overrun !== m_ovr) begin bad++; $display("FAIL rand_overrun c=%0d got=%b exp=%b", c, overrun, m_ovr); end
    end
    clear = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dwell();
    test_overrun();
    test_drain_coincident();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_sampler.md
Name: mux_scan_sampler

Overview:
- Scan controller that sits directly upstream of the 4:1 select-line multiplexer (two-level 2:1 mux tree, D[3:0]/sel[1:0]/out).
- Drives the mux `sel` lines through channels 0..3, holds each channel for a programmable settle time, and samples the combinational mux output.
- Packs the four samples into a 4-bit word and hands it downstream over a valid/ready interface.
- A one-entry output buffer sits between the scanner and the consumer. When the consumer cannot take a word in time, the word is dropped and an overrun flag is raised.

Parameters:
- DWELL_W, 4, width of the per-channel settle count (extra wait cycles per channel).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  scan enable; level-sensitive.
- dwell  in  DWELL_W  extra settle cycles per channel. Captured at the start of each channel.
- mux_out  in  1  combinational output of the downstream 4:1 mux.
- sel  out  2  channel select driven to the mux.
- word  out  4  assembled sample word; bit i = sample taken with sel==i.
- word_valid  out  1  word holds an unconsumed result.
- word_ready  in  1  consumer accepts word when word_valid && word_ready.
- overrun  out  1  sticky: a completed word was dropped.
- clear  in  1  clears overrun.

Behaviour:
- Reset (rst_n==0 at an edge):
  - state=IDLE, sel=0, cnt=0, shadow=0.
  - word=0, word_valid=0, overrun=0.
  - Reset overrides every other input, including mid-scan.
- State IDLE:
  - sel=0.
  - en==1 → SETTLE, sel=0, cnt=0, dwell latched into dwell_q.
- State SETTLE (channel sel):
  - Leaving SETTLE:
    - en==0 → IDLE next cycle; sel=0; partial shadow discarded.
    - The output buffer and overrun are unaffected.
  - Waiting: cnt<dwell_q → cnt++.
  - Sampling: cnt==dwell_q → shadow[sel]<=mux_out.
    - sel<3: sel<=sel+1, cnt<=0, dwell re-latched; stay in SETTLE.
    - sel==3: scan complete. sel wraps to 0, cnt<=0, dwell re-latched, stay in SETTLE. No idle gap between scans.
  - dwell=0 samples in the first cycle of each channel.
- Timing:
  - Per channel: dwell+1 cycles.
  - Scan period: 4*(dwell+1) cycles.
  - First word_valid: 1+4*(dwell+1) edges after the edge that samples en==1 in IDLE (5 edges for dwell=0).
- Word completion (the cycle shadow[3] is captured):
  - The new word is {mux_out, shadow[2:0]}.
  - Buffer free (word_valid==0), or drained this cycle (word_valid && word_ready): word<=new word, word_valid<=1.
  - Otherwise: new word dropped, old word retained unchanged, overrun<=1.
- Handshake:
  - word_valid and word stay stable until accepted.
  - Acceptance with no simultaneous completion → word_valid<=0 next cycle; word holds its last value.
- overrun:
  - clear==1 → overrun<=0.
  - Simultaneous drop and clear → overrun=1 (set wins).
- en toggles:
  - en re-asserted after an abort restarts at channel 0 with a fresh shadow.
  - en==0 during a completion cycle is an abort: that word is not delivered.

Test Plan:
- Reset: rst_n=0 for 2 cycles with en=1, word_ready=1 → sel=0, word=0, word_valid=0, overrun=0; no sampling during reset.
- Basic scan: mux model out=D[sel], D=4'b1010, dwell=0, en=1, word_ready=1.
  - sel sequence 0,1,2,3,0,...
  - word_valid pulses 5 edges after en, with word=4'b1010.
  - Further words every 4 cycles.
- Dwell: dwell=3, D=4'b0110, D changed to 4'b1001 two cycles into channel 0 → sel holds 4 cycles per channel; bit0 takes the value at the last settle cycle; word=4'b1001.
- Backpressure/overrun: word_ready=0, dwell=0, D=4'b0011, then D=4'b1100 after first word.
  - word=4'b0011 is held.
  - Second completion drops 4'b1100; overrun=1.
  - clear=1 with no drop → overrun=0.
  - clear=1 on a drop cycle → overrun stays 1.
- Drain coincident with completion: word_ready=1 exactly on the completion cycle of scan 2 → word updates to the new value with word_valid held at 1, overrun=0.
- Abort and restart: en=0 while sel==2 → IDLE next cycle, sel=0, no word emitted.
  - en=1 with D=4'b0101 → full fresh scan; word=4'b0101.
  - Any previously buffered word is intact until consumed.
